ball_handoff_sequencer: RTL
===========================

// Module: ball_handoff_sequencer
// PURPOSE
//  Sequences ball hand-off between the two boards. On the local game FSM's ball_send_trigger it
//  latches ball y/vy, drives an I2C-master write of 4 regs (y0,y1,speed,trig), retries on error/timeout.
//  On the receive side it filters I2C-slave regs slv_reg0..3 and emits a 1-cycle go_right with the
//  latched y/vy. Sits between game_controller and the I2C master/slave.
// PARAMETERS
//  MAX_RETRY    3        tx attempts after the first before FAIL
//  ACK_TIMEOUT  250000   cycles (10 ms @25 MHz) waiting tx_done/tx_err per attempt
//  BACKOFF_CYC  25000    idle cycles between attempts
//  RX_STABLE    4        cycles slv_reg3_trig must hold unchanged before acceptance
// PORTS
//  clk_25MHZ         in   1   clock
//  reset             in   1   asynchronous, active-high
//  ball_send_trigger in   1   level from game FSM (high while ball left the local field)
//  ball_y            in   10  local ball y at trigger
//  ball_vy           in   8   local signed y velocity at trigger
//  tx_busy           in   1   I2C master busy
//  tx_done           in   1   1-cycle pulse, write ACKed
//  tx_err            in   1   1-cycle pulse, NACK/arbitration loss
//  tx_start          out  1   1-cycle pulse, start 4-byte write
//  tx_y0,tx_y1       out  8   {6'b0,y[9:8]}, y[7:0]
//  tx_speed          out  8   vy
//  tx_trig           out  8   {TRIG_MAGIC,seq}
//  slv_reg0_y0..slv_reg3_trig in 8 each  I2C slave register file
//  go_right          out  1   1-cycle pulse, valid incoming ball
//  rx_y              out  10  {slv_reg0_y0[1:0],slv_reg1_y1} latched at acceptance
//  rx_vy             out  8   slv_reg2_speed latched at acceptance
//  tx_fail           out  1   sticky until next ball_send_trigger rising edge
// BEHAVIOUR
//  Reset: tx_start=0, tx_*=0, go_right=0, rx_y=0, rx_vy=0, tx_fail=0, seq=0, last_rx_seq=1, FSM=IDLE.
//  TX FSM: IDLE -> LATCH on rising edge of ball_send_trigger (edge-detect reg; level ignored).
//   LATCH (1 cyc): capture ball_y/ball_vy into tx_*, seq<=~seq, retry_cnt<=0, tx_fail<=0 -> SEND.
//   SEND: wait !tx_busy, then tx_start=1 for exactly 1 cycle, timer<=0 -> WAIT.
//   WAIT: tx_done -> HOLD; tx_err or timer==ACK_TIMEOUT-1 -> retry_cnt==MAX_RETRY ? FAIL : BACKOFF.
//   BACKOFF: count BACKOFF_CYC, retry_cnt++ -> SEND. Same seq reused on every retry.
//   HOLD/FAIL: wait ball_send_trigger==0 -> IDLE. FAIL sets tx_fail=1.
//   tx_done and tx_err in same cycle: tx_done wins. tx_done outside WAIT: ignored.
//  tx_* outputs stable from LATCH until next LATCH; first tx_start no earlier than 2 cycles after edge.
//  RX path: valid when slv_reg3_trig[7:1]==TRIG_MAGIC and bit0!=last_rx_seq and value unchanged
//   for RX_STABLE consecutive cycles (guards torn multi-byte writes). On acceptance: latch rx_y/rx_vy,
//   last_rx_seq<=bit0, go_right=1 next cycle for 1 cycle. Same seq never re-fires go_right.
//   Counter restarts on any slv_reg3_trig change; wrong magic never accepted.
//  RX and TX independent: simultaneous trigger edge and rx acceptance both processed same cycle.
//  Reset mid-operation: all state to reset values; partial I2C transfer is owned by the master.
//  Counters saturate, never wrap; timer width $clog2(ACK_TIMEOUT+1).
// STRUCTURE
//  handoff_pkg: typedef enum {IDLE,LATCH,SEND,WAIT,BACKOFF,HOLD,FAIL} tx_state_t;
//   localparam TRIG_MAGIC=7'h52; packing function pack_y(y)->{y0,y1}.
//  Sub-module handoff_rx_filter: stability counter + seq compare + rx latch + go_right pulse.
//  Top: TX FSM, timer, retry counter, edge detect.
// TESTING
//  1 trigger rises, ball_y=10'h2A5, vy=-3; tx_done 50 cyc after tx_start -> one tx_start,
//    tx_y0=02,tx_y1=A5,tx_speed=FD,tx_trig=A5 (seq=1), HOLD until trigger low.
//  2 tx_err on attempts 1..4 -> exactly 4 tx_start pulses, BACKOFF_CYC apart, tx_fail=1, tx_trig constant.
//  3 no tx_done -> timeout at ACK_TIMEOUT cycles, retry; tx_done on retry 2 -> HOLD, tx_fail=0.
//  4 slave regs y0=01,y1=40,speed=05,trig=A5 held 4 cyc -> go_right 1 pulse, rx_y=0x140, rx_vy=5;
//    hold A5 1000 cyc -> no second pulse; then A4 -> second pulse.
//  5 trig toggles A5<->A4 every 2 cycles, or trig=B5 -> go_right never asserts.
//  6 reset asserted in WAIT and during RX stability count -> all outputs 0 next edge, no tx_start/go_right.

Source files
------------

// File: rtl/handoff_pkg.sv
// Shared types and helpers for the inter-board ball hand-off sequencer.
package handoff_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned Y_W    = 10;
  localparam int unsigned VY_W   = 8;

  localparam logic [6:0] TRIG_MAGIC = 7'h52;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    SEND,
    WAIT,
    BACKOFF,
    HOLD,
    FAIL
  } tx_state_t;

  typedef struct packed {
    logic [BYTE_W-1:0] y0;
    logic [BYTE_W-1:0] y1;
  } y_bytes_t;

  // Splits a 10-bit y into the two wire bytes {6'b0,y[9:8]}, y[7:0].
  function automatic y_bytes_t pack_y(input logic [Y_W-1:0] y);
    y_bytes_t b;
    b.y0 = {6'b0, y[9:8]};
    b.y1 = y[7:0];
    return b;
  endfunction

endpackage

// File: rtl/handoff_rx_filter.sv
// Receive side: accepts a new ball from the I2C slave regs once the trigger byte is stable.
module handoff_rx_filter
  import handoff_pkg::*;
#(
  parameter int unsigned RX_STABLE = 4
) (
  input  logic              clk_25MHZ,
  input  logic              reset,
  input  logic [BYTE_W-1:0] slv_reg0_y0,
  input  logic [BYTE_W-1:0] slv_reg1_y1,
  input  logic [BYTE_W-1:0] slv_reg2_speed,
  input  logic [BYTE_W-1:0] slv_reg3_trig,
  output logic              go_right,
  output logic [Y_W-1:0]    rx_y,
  output logic [VY_W-1:0]   rx_vy
);

  localparam int unsigned CNT_W = $clog2(RX_STABLE + 1);

  logic [BYTE_W-1:0] trig_prev_q;
  logic [CNT_W-1:0]  stable_cnt_q, stable_cnt_d;
  logic              last_seq_q;
  logic              seq_seen_q;
  logic              go_right_q;
  logic [Y_W-1:0]    rx_y_q;
  logic [VY_W-1:0]   rx_vy_q;
  logic              accept_c;

  // seq_seen_q lets the very first valid trigger through even though last_seq resets to 1.
  always_comb begin
    stable_cnt_d = stable_cnt_q;
    if (slv_reg3_trig != trig_prev_q) begin
      stable_cnt_d = CNT_W'(1);
    end else if (stable_cnt_q != CNT_W'(RX_STABLE)) begin
      stable_cnt_d = stable_cnt_q + CNT_W'(1);
    end
    accept_c = (slv_reg3_trig[7:1] == TRIG_MAGIC)
            && (!seq_seen_q || (slv_reg3_trig[0] != last_seq_q))
            && (stable_cnt_d == CNT_W'(RX_STABLE));
  end

  always_ff @(posedge clk_25MHZ or posedge reset) begin
    if (reset) begin
      trig_prev_q  <= '0;
      stable_cnt_q <= '0;
      last_seq_q   <= 1'b1;
      seq_seen_q   <= 1'b0;
      go_right_q   <= 1'b0;
      rx_y_q       <= '0;
      rx_vy_q      <= '0;
    end else begin
      trig_prev_q  <= slv_reg3_trig;
      stable_cnt_q <= stable_cnt_d;
      go_right_q   <= accept_c;
      if (accept_c) begin
        last_seq_q <= slv_reg3_trig[0];
        seq_seen_q <= 1'b1;
        rx_y_q     <= {slv_reg0_y0[1:0], slv_reg1_y1};
        rx_vy_q    <= slv_reg2_speed;
      end
    end
  end

  assign go_right = go_right_q;
  assign rx_y     = rx_y_q;
  assign rx_vy    = rx_vy_q;

endmodule

// File: rtl/ball_handoff_sequencer.sv
// Ball hand-off between boards: TX retry FSM toward the I2C master plus the RX acceptance filter.
module ball_handoff_sequencer
  import handoff_pkg::*;
#(
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned ACK_TIMEOUT = 250000,
  parameter int unsigned BACKOFF_CYC = 25000,
  parameter int unsigned RX_STABLE   = 4
) (
  input  logic              clk_25MHZ,
  input  logic              reset,
  input  logic              ball_send_trigger,
  input  logic [Y_W-1:0]    ball_y,
  input  logic [VY_W-1:0]   ball_vy,
  input  logic              tx_busy,
  input  logic              tx_done,
  input  logic              tx_err,
  output logic              tx_start,
  output logic [BYTE_W-1:0] tx_y0,
  output logic [BYTE_W-1:0] tx_y1,
  output logic [BYTE_W-1:0] tx_speed,
  output logic [BYTE_W-1:0] tx_trig,
  input  logic [BYTE_W-1:0] slv_reg0_y0,
  input  logic [BYTE_W-1:0] slv_reg1_y1,
  input  logic [BYTE_W-1:0] slv_reg2_speed,
  input  logic [BYTE_W-1:0] slv_reg3_trig,
  output logic              go_right,
  output logic [Y_W-1:0]    rx_y,
  output logic [VY_W-1:0]   rx_vy,
  output logic              tx_fail
);

  localparam int unsigned TMR_W   = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned BOFF_W  = $clog2(BACKOFF_CYC + 1);
  localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);

  tx_state_t         state_q, state_d;
  logic              trig_q;
  logic              seq_q, seq_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [BOFF_W-1:0] boff_q, boff_d;
  logic              tx_start_q, tx_start_d;
  logic              tx_fail_q, tx_fail_d;
  y_bytes_t          tx_ybytes_q, tx_ybytes_d;
  logic [BYTE_W-1:0] tx_speed_q, tx_speed_d;
  logic [BYTE_W-1:0] tx_trig_q, tx_trig_d;
  logic              rise_c;

  assign rise_c = ball_send_trigger & ~trig_q;

  always_ff @(posedge clk_25MHZ or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      trig_q      <= 1'b0;
      seq_q       <= 1'b0;
      retry_q     <= '0;
      timer_q     <= '0;
      boff_q      <= '0;
      tx_start_q  <= 1'b0;
      tx_fail_q   <= 1'b0;
      tx_ybytes_q <= '0;
      tx_speed_q  <= '0;
      tx_trig_q   <= '0;
    end else begin
      state_q     <= state_d;
      trig_q      <= ball_send_trigger;
      seq_q       <= seq_d;
      retry_q     <= retry_d;
      timer_q     <= timer_d;
      boff_q      <= boff_d;
      tx_start_q  <= tx_start_d;
      tx_fail_q   <= tx_fail_d;
      tx_ybytes_q <= tx_ybytes_d;
      tx_speed_q  <= tx_speed_d;
      tx_trig_q   <= tx_trig_d;
    end
  end

  // TX sequencing; the same seq is reused across all retries of one ball.
  always_comb begin
    state_d     = state_q;
    seq_d       = seq_q;
    retry_d     = retry_q;
    timer_d     = timer_q;
    boff_d      = boff_q;
    tx_start_d  = 1'b0;
    tx_fail_d   = tx_fail_q;
    tx_ybytes_d = tx_ybytes_q;
    tx_speed_d  = tx_speed_q;
    tx_trig_d   = tx_trig_q;
    case (state_q)
      IDLE: begin
        if (rise_c) state_d = LATCH;
      end
      LATCH: begin
        tx_ybytes_d = pack_y(ball_y);
        tx_speed_d  = ball_vy;
        tx_trig_d   = {TRIG_MAGIC, ~seq_q};
        seq_d       = ~seq_q;
        retry_d     = '0;
        tx_fail_d   = 1'b0;
        state_d     = SEND;
      end
      SEND: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          timer_d    = '0;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (timer_q != TMR_W'(ACK_TIMEOUT - 1)) timer_d = timer_q + TMR_W'(1);
        if (tx_done) begin
          state_d = HOLD;
        end else if (tx_err || (timer_q == TMR_W'(ACK_TIMEOUT - 1))) begin
          if (retry_q == RETRY_W'(MAX_RETRY)) begin
            tx_fail_d = 1'b1;
            state_d   = FAIL;
          end else begin
            boff_d  = '0;
            state_d = BACKOFF;
          end
        end
      end
      BACKOFF: begin
        if (boff_q == BOFF_W'(BACKOFF_CYC - 1)) begin
          if (retry_q != RETRY_W'(MAX_RETRY)) retry_d = retry_q + RETRY_W'(1);
          state_d = SEND;
        end else begin
          boff_d = boff_q + BOFF_W'(1);
        end
      end
      HOLD, FAIL: begin
        if (!ball_send_trigger) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_start = tx_start_q;
  assign tx_fail  = tx_fail_q;
  assign tx_y0    = tx_ybytes_q.y0;
  assign tx_y1    = tx_ybytes_q.y1;
  assign tx_speed = tx_speed_q;
  assign tx_trig  = tx_trig_q;

  handoff_rx_filter #(
    .RX_STABLE(RX_STABLE)
  ) u_rx_filter (
    .clk_25MHZ     (clk_25MHZ),
    .reset         (reset),
    .slv_reg0_y0   (slv_reg0_y0),
    .slv_reg1_y1   (slv_reg1_y1),
    .slv_reg2_speed(slv_reg2_speed),
    .slv_reg3_trig (slv_reg3_trig),
    .go_right      (go_right),
    .rx_y          (rx_y),
    .rx_vy         (rx_vy)
  );

endmodule
